// File: rtl/axil_sram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : axil_sram_bridge
//  Description : AXI4-Lite slave that maps the read channel onto a read-only
//                SRAM port A and the write channels onto a byte-masked,
//                write-only SRAM port B. Each path allows one transaction in
//                flight. Optional macro AXIL_SRAM_RANGE_CHECK_EN turns
//                out-of-window addresses into SLVERR with no SRAM access.
//  Revision    : 1.0  initial release
// ============================================================================
module axil_sram_bridge #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int BYTE_W     = DATA_W / 8,
  parameter int AXI_ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // AXI4-Lite write address / data / response
  input  logic [AXI_ADDR_W-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [BYTE_W-1:0]     s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  // AXI4-Lite read address / data
  input  logic [AXI_ADDR_W-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_W-1:0]     s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  // SRAM port A (read)
  output logic                  a_en,
  output logic                  a_re,
  output logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_rdata,
  input  logic                  a_rvalid,
  // SRAM port B (write)
  output logic                  b_en,
  output logic                  b_we,
  output logic [ADDR_W-1:0]     b_addr,
  output logic [DATA_W-1:0]     b_wdata,
  output logic [BYTE_W-1:0]     b_wmask
);

  localparam logic [1:0] C_RESP_OKAY   = 2'b00;
  localparam logic [1:0] C_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_COLLECT = 2'd0,
    W_ISSUE   = 2'd1,
    W_RESP    = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_WAIT = 2'd2,
    R_RESP = 2'd3
  } rd_state_t;

  wr_state_t             r_wr_state;
  rd_state_t             r_rd_state;

  logic                  r_aw_full;
  logic [ADDR_W-1:0]     r_aw_idx;
  logic                  r_aw_oor;
  logic                  r_w_full;
  logic [DATA_W-1:0]     r_w_data;
  logic [BYTE_W-1:0]     r_w_strb;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_issue_clr;
  logic                  w_aw_full_nxt;
  logic                  w_w_full_nxt;
  logic                  w_aw_oor;
  logic                  w_ar_oor;
  logic                  w_unused;

  assign w_aw_hs     = s_awvalid & s_awready;
  assign w_w_hs      = s_wvalid  & s_wready;
  assign w_ar_hs     = s_arvalid & s_arready;
  assign w_issue_clr = (r_wr_state == W_ISSUE);

  // Buffers empty at the end of the issue cycle, so ready reopens in W_RESP.
  assign w_aw_full_nxt = (r_aw_full | w_aw_hs) & ~w_issue_clr;
  assign w_w_full_nxt  = (r_w_full  | w_w_hs)  & ~w_issue_clr;

`ifdef AXIL_SRAM_RANGE_CHECK_EN
  assign w_aw_oor = |s_awaddr[AXI_ADDR_W-1:ADDR_W+2];
  assign w_ar_oor = |s_araddr[AXI_ADDR_W-1:ADDR_W+2];
  assign w_unused = ^{s_awaddr[1:0], s_araddr[1:0]};
`else
  // Upper address bits are ignored: the SRAM aliases across the address space.
  assign w_aw_oor = 1'b0;
  assign w_ar_oor = 1'b0;
  assign w_unused = ^{s_awaddr[AXI_ADDR_W-1:ADDR_W+2], s_awaddr[1:0],
                      s_araddr[AXI_ADDR_W-1:ADDR_W+2], s_araddr[1:0]};
`endif

  // --------------------------------------------------------------------------
  // Write path
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_state <= W_COLLECT;
      r_aw_full  <= 1'b0;
      r_aw_idx   <= '0;
      r_aw_oor   <= 1'b0;
      r_w_full   <= 1'b0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
      s_awready  <= 1'b0;
      s_wready   <= 1'b0;
      s_bvalid   <= 1'b0;
      s_bresp    <= C_RESP_OKAY;
      b_en       <= 1'b0;
      b_we       <= 1'b0;
      b_addr     <= '0;
      b_wdata    <= '0;
      b_wmask    <= '0;
    end else begin
      r_aw_full <= w_aw_full_nxt;
      r_w_full  <= w_w_full_nxt;
      s_awready <= ~w_aw_full_nxt;
      s_wready  <= ~w_w_full_nxt;

      if (w_aw_hs) begin
        r_aw_idx <= s_awaddr[ADDR_W+1:2];
        r_aw_oor <= w_aw_oor;
      end
      if (w_w_hs) begin
        r_w_data <= s_wdata;
        r_w_strb <= s_wstrb;
      end

      case (r_wr_state)
        W_COLLECT: begin
          if (r_aw_full && r_w_full && !s_bvalid) begin
            b_en       <= ~r_aw_oor;
            b_we       <= ~r_aw_oor;
            b_addr     <= r_aw_idx;
            b_wdata    <= r_w_data;
            b_wmask    <= r_w_strb;
            r_wr_state <= W_ISSUE;
          end
        end
        W_ISSUE: begin
          b_en       <= 1'b0;
          b_we       <= 1'b0;
          s_bvalid   <= 1'b1;
          s_bresp    <= r_aw_oor ? C_RESP_SLVERR : C_RESP_OKAY;
          r_wr_state <= W_RESP;
        end
        W_RESP: begin
          if (s_bready) begin
            s_bvalid   <= 1'b0;
            r_wr_state <= W_COLLECT;
          end
        end
        default: r_wr_state <= W_COLLECT;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      s_arready  <= 1'b0;
      s_rvalid   <= 1'b0;
      s_rdata    <= '0;
      s_rresp    <= C_RESP_OKAY;
      a_en       <= 1'b0;
      a_re       <= 1'b0;
      a_addr     <= '0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (w_ar_hs) begin
            s_arready <= 1'b0;
            if (w_ar_oor) begin
              s_rdata    <= '0;
              s_rresp    <= C_RESP_SLVERR;
              s_rvalid   <= 1'b1;
              r_rd_state <= R_RESP;
            end else begin
              a_en       <= 1'b1;
              a_re       <= 1'b1;
              a_addr     <= s_araddr[ADDR_W+1:2];
              r_rd_state <= R_REQ;
            end
          end else begin
            s_arready <= 1'b1;
          end
        end
        R_REQ: begin
          a_en       <= 1'b0;
          a_re       <= 1'b0;
          r_rd_state <= R_WAIT;
        end
        R_WAIT: begin
          if (a_rvalid) begin
            s_rdata    <= a_rdata;
            s_rresp    <= C_RESP_OKAY;
            s_rvalid   <= 1'b1;
            r_rd_state <= R_RESP;
          end
        end
        R_RESP: begin
          if (s_rready) begin
            s_rvalid   <= 1'b0;
            s_arready  <= 1'b1;
            r_rd_state <= R_IDLE;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axil_sram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axil_sram_bridge
//  Description : Directed bench for axil_sram_bridge with a 2-cycle SRAM model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axil_sram_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b0;
  logic [31:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic        a_en, a_re;
  logic [9:0]  a_addr;
  logic [31:0] a_rdata;
  logic        a_rvalid;
  logic        b_en, b_we;
  logic [9:0]  b_addr;
  logic [31:0] b_wdata;
  logic [3:0]  b_wmask;

  int checks   = 0;
  int failures = 0;

  axil_sram_bridge dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .a_en(a_en), .a_re(a_re), .a_addr(a_addr), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_wmask(b_wmask)
  );

  always #5 clk = ~clk;

  // SRAM model: write-first, read data returned two cycles after the request cycle.
  logic [31:0] mem [0:1023];
  logic        st1_v = 1'b0;
  logic [31:0] st1_d = '0;
  logic [31:0] rd_fwd;
  initial a_rvalid = 1'b0;
  initial a_rdata  = '0;
  initial for (int i = 0; i < 1024; i++) mem[i] = '0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? d[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  assign rd_fwd = (b_en && b_we && b_addr == a_addr) ? merge(mem[a_addr], b_wdata, b_wmask)
                                                       : mem[a_addr];

  always @(posedge clk) begin
    if (b_en && b_we) mem[b_addr] <= merge(mem[b_addr], b_wdata, b_wmask);
    st1_v    <= a_en && a_re;
    st1_d    <= rd_fwd;
    a_rvalid <= st1_v;
    a_rdata  <= st1_d;
  end

  // Strobe observers
  int         ben_cnt = 0, aen_cnt = 0, we_mis = 0, re_mis = 0;
  logic [9:0] last_baddr = '0;
  logic [3:0] last_bmask = '0;
  always @(posedge clk) begin
    if (b_en) begin
      ben_cnt    <= ben_cnt + 1;
      last_baddr <= b_addr;
      last_bmask <= b_wmask;
    end
    if (a_en) aen_cnt <= aen_cnt + 1;
    if (b_en !== b_we) we_mis <= we_mis + 1;
    if (a_en !== a_re) re_mis <= re_mis + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // All bus tasks start and end on a negedge.
  task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly);
    bit aw_hs = 0;
    bit w_hs  = 0;
    int n     = 0;
    s_awaddr  = addr;
    s_wdata   = data;
    s_wstrb   = strb;
    s_awvalid = (aw_dly == 0);
    s_wvalid  = (w_dly == 0);
    while (!(aw_hs && w_hs) && n < 64) begin
      if (s_awvalid && s_awready) aw_hs = 1;
      if (s_wvalid && s_wready) w_hs = 1;
      @(negedge clk);
      n++;
      s_awvalid = !aw_hs && (n >= aw_dly);
      s_wvalid  = !w_hs && (n >= w_dly);
    end
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    chk("aw_w_accepted", {62'd0, aw_hs, w_hs}, 64'd3);
  endtask

  task automatic wait_b(output logic [1:0] resp);
    int n = 0;
    s_bready = 1'b1;
    while (!s_bvalid && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("b_valid_seen", s_bvalid, 1);
    resp = s_bresp;
    @(negedge clk);
    s_bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    int n = 0;
    s_rready  = 1'b1;
    s_araddr  = addr;
    s_arvalid = 1'b1;
    while (!s_arready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("ar_accepted", s_arready, 1);
    @(negedge clk);
    s_arvalid = 1'b0;
    lat = 1;
    while (!s_rvalid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk("r_valid_seen", s_rvalid, 1);
    data = s_rdata;
    resp = s_rresp;
    @(negedge clk);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int          exp_pulses;
    int          exp_lat;
  } vec_t;

  localparam int NV = 16;
  vec_t vt [NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdata, d0;
    logic [1:0]  resp;
    int          lat, c0, n;
    bit          seen;

    vt[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 2, 32'h0,        2'b00, 1, 0};
    vt[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 0, 0, 32'hDEADBEEF, 2'b00, 1, 4};
    vt[2]  = '{1'b1, 32'h10,   32'h0000CAFE, 4'h3, 0, 0, 32'h0,        2'b00, 1, 0};
    vt[3]  = '{1'b0, 32'h10,   32'h0,        4'h0, 0, 0, 32'hDEADCAFE, 2'b00, 1, 4};
    vt[4]  = '{1'b1, 32'h13,   32'h11223344, 4'hC, 0, 1, 32'h0,        2'b00, 1, 0};
    vt[5]  = '{1'b0, 32'h12,   32'h0,        4'h0, 0, 0, 32'h1122CAFE, 2'b00, 1, 4};
    vt[6]  = '{1'b1, 32'h20,   32'h55AA55AA, 4'hF, 2, 0, 32'h0,        2'b00, 1, 0};
    vt[7]  = '{1'b0, 32'h20,   32'h0,        4'h0, 0, 0, 32'h55AA55AA, 2'b00, 1, 4};
    vt[8]  = '{1'b1, 32'hFFC,  32'hA5A5A5A5, 4'hF, 0, 0, 32'h0,        2'b00, 1, 0};
    vt[9]  = '{1'b0, 32'hFFC,  32'h0,        4'h0, 0, 0, 32'hA5A5A5A5, 2'b00, 1, 4};
    vt[10] = '{1'b1, 32'h0,    32'h12345678, 4'h0, 0, 0, 32'h0,        2'b00, 1, 0};
    vt[11] = '{1'b0, 32'h0,    32'h0,        4'h0, 0, 0, 32'h00000000, 2'b00, 1, 4};
`ifdef AXIL_SRAM_RANGE_CHECK_EN
    vt[12] = '{1'b1, 32'h1010, 32'h0BADF00D, 4'hF, 0, 0, 32'h0,        2'b10, 0, 0};
    vt[13] = '{1'b0, 32'h10,   32'h0,        4'h0, 0, 0, 32'h1122CAFE, 2'b00, 1, 4};
    vt[14] = '{1'b0, 32'h1010, 32'h0,        4'h0, 0, 0, 32'h00000000, 2'b10, 0, 1};
    vt[15] = '{1'b0, 32'h1000, 32'h0,        4'h0, 0, 0, 32'h00000000, 2'b10, 0, 1};
`else
    vt[12] = '{1'b1, 32'h1010, 32'h0BADF00D, 4'hF, 0, 0, 32'h0,        2'b00, 1, 0};
    vt[13] = '{1'b0, 32'h10,   32'h0,        4'h0, 0, 0, 32'h0BADF00D, 2'b00, 1, 4};
    vt[14] = '{1'b0, 32'h1010, 32'h0,        4'h0, 0, 0, 32'h0BADF00D, 2'b00, 1, 4};
    vt[15] = '{1'b0, 32'h1000, 32'h0,        4'h0, 0, 0, 32'h00000000, 2'b00, 1, 4};
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, a_en, b_en}, 0);
    chk("reset_rdata", s_rdata, 0);
    chk("reset_resp_addr", {s_bresp, s_rresp, b_addr, a_addr}, 0);
    chk("reset_bdata", {b_wdata, b_wmask}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {s_awready, s_wready, s_arready}, 3'b111);

    // Table-driven transactions
    for (int i = 0; i < NV; i++) begin
      if (vt[i].wr) begin
        c0 = ben_cnt;
        send_aw_w(vt[i].addr, vt[i].data, vt[i].strb, vt[i].aw_dly, vt[i].w_dly);
        wait_b(resp);
        chk($sformatf("v%0d_bresp", i), resp, vt[i].exp_resp);
        chk($sformatf("v%0d_b_en_pulses", i), ben_cnt - c0, vt[i].exp_pulses);
        if (vt[i].exp_pulses > 0) begin
          chk($sformatf("v%0d_b_addr", i), last_baddr, (vt[i].addr >> 2) & 32'h3FF);
          chk($sformatf("v%0d_b_wmask", i), last_bmask, vt[i].strb);
        end
      end else begin
        c0 = aen_cnt;
        do_read(vt[i].addr, rdata, resp, lat);
        chk($sformatf("v%0d_rdata", i), rdata, vt[i].exp_data);
        chk($sformatf("v%0d_rresp", i), resp, vt[i].exp_resp);
        chk($sformatf("v%0d_a_en_pulses", i), aen_cnt - c0, vt[i].exp_pulses);
        chk($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
      end
    end

    // B backpressure: second write accepted during W_RESP but issued after B handshake
    s_bready = 1'b0;
    c0 = ben_cnt;
    send_aw_w(32'h40, 32'h01020304, 4'hF, 0, 0);
    repeat (5) @(negedge clk);
    chk("bstall_bvalid_held", s_bvalid, 1);
    chk("bstall_first_pulse", ben_cnt - c0, 1);
    send_aw_w(32'h44, 32'h0A0B0C0D, 4'hF, 0, 0);
    repeat (3) @(negedge clk);
    chk("bstall_second_waits", ben_cnt - c0, 1);
    chk("bstall_bvalid_still", s_bvalid, 1);
    wait_b(resp);
    chk("bstall_first_bresp", resp, 2'b00);
    wait_b(resp);
    chk("bstall_second_bresp", resp, 2'b00);
    chk("bstall_second_pulse", ben_cnt - c0, 2);
    chk("bstall_second_addr", last_baddr, 10'h11);
    do_read(32'h44, rdata, resp, lat);
    chk("bstall_readback", rdata, 32'h0A0B0C0D);

    // R backpressure: data and valid held, no new AR accepted, no extra a_en
    s_rready  = 1'b0;
    c0        = aen_cnt;
    s_araddr  = 32'h40;
    s_arvalid = 1'b1;
    n = 0;
    while (!s_arready && n < 64) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    s_arvalid = 1'b0;
    n = 0;
    while (!s_rvalid && n < 64) begin
      @(negedge clk);
      n++;
    end
    d0 = s_rdata;
    chk("rstall_first_data", d0, 32'h01020304);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rstall_rvalid_held", s_rvalid, 1);
      chk("rstall_rdata_stable", s_rdata, d0);
      chk("rstall_arready_low", s_arready, 0);
    end
    chk("rstall_single_a_en", aen_cnt - c0, 1);
    s_rready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rstall_released", s_rvalid, 0);

    // Reset while waiting for SRAM data: response must be dropped
    s_araddr  = 32'h40;
    s_arvalid = 1'b1;
    n = 0;
    while (!s_arready && n < 64) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    s_arvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (s_rvalid) seen = 1;
    end
    chk("rst_mid_read_no_rvalid", seen, 0);
    chk("rst_mid_read_arready", s_arready, 1);

    chk("b_we_tracks_b_en", we_mis, 0);
    chk("a_re_tracks_a_en", re_mis, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
